// File: rtl/decode_queue.sv
// Instruction decode queue: a small circular FIFO of {pc, instr} followed by
// a single registered output stage that holds the fully decoded bundle.
package decode_queue_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_OP_IMM = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } inst_format_t;

  // Encoding is {funct7[5], funct3} so OP decodes without a lookup table.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [31:0]                  in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output inst_format_t                 out_format,
  output logic [REG_ADDR_W-1:0]        out_rs1,
  output logic [REG_ADDR_W-1:0]        out_rs2,
  output logic [REG_ADDR_W-1:0]        out_rd,
  output logic                         out_branch,
  output logic                         out_jump,
  output logic                         out_alu_imm,
  output logic                         out_alu_pc,
  output alu_op_t                      out_alu_op,
  output logic                         out_mem_read,
  output logic                         out_mem_write,
  output logic                         out_mem_unsigned,
  output logic [1:0]                   out_mem_size,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic push;
  logic pop;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // The head moves into the output stage whenever that stage is empty or draining.
  assign pop      = (count != '0) && (!out_valid || out_ready);

  logic [31:0] h_pc;
  logic [31:0] h_instr;
  logic [6:0]  opc;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign h_pc    = mem_pc[rd_ptr];
  assign h_instr = mem_instr[rd_ptr];
  assign opc     = h_instr[6:0];
  assign funct3  = h_instr[14:12];
  assign funct7  = h_instr[31:25];

  inst_format_t d_format;
  alu_op_t      d_alu_op;
  logic         d_branch, d_jump, d_alu_imm, d_alu_pc;
  logic         d_mem_read, d_mem_write, d_illegal;
  logic         bad_op, bad_reg;
  logic         use_rd, use_rs1, use_rs2;

  // Storage write: slots beyond count are don't-care, so a discarded push may land harmlessly.
  // NOTE: the storage array carries no reset; count and the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
    end
  end

  // Decode the FIFO head so the output stage loads a finished bundle.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    d_format    = I_TYPE;
    d_alu_op    = ALU_ADD;
    d_branch    = 1'b0;
    d_jump      = 1'b0;
    d_alu_imm   = 1'b1;
    d_alu_pc    = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    bad_op      = 1'b0;
    use_rd      = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (opc)
      OP_OP: begin
        d_format  = R_TYPE;
        d_alu_imm = 1'b0;
        d_alu_op  = alu_op_t'({funct7[5], funct3});
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        if (funct7 != 7'h00 && funct7 != 7'h20)
          bad_op = 1'b1;
        else if (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101)
          bad_op = 1'b1;
      end
      OP_OP_IMM: begin
        // Immediate bit 10 only selects SRA; for other ops it is immediate data.
        d_alu_op = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA : alu_op_t'({1'b0, funct3});
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
      end
      OP_LOAD: begin
        d_mem_read = 1'b1;
        use_rd     = 1'b1;
        use_rs1    = 1'b1;
      end
      OP_STORE: begin
        d_format    = S_TYPE;
        d_mem_write = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_BRANCH: begin
        d_format = B_TYPE;
        d_branch = 1'b1;
        d_alu_pc = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_JAL: begin
        d_format = J_TYPE;
        d_jump   = 1'b1;
        d_alu_pc = 1'b1;
        use_rd   = 1'b1;
      end
      OP_JALR: begin
        d_jump  = 1'b1;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_LUI: begin
        d_format = U_TYPE;
        use_rd   = 1'b1;
      end
      OP_AUIPC: begin
        d_format = U_TYPE;
        d_alu_pc = 1'b1;
        use_rd   = 1'b1;
      end
      default: bad_op = 1'b1;
    endcase

    // With 16 registers, any referenced register field above x15 is unencodable.
    bad_reg = 1'b0;
    if (REG_ADDR_W == 4)
      bad_reg = (use_rd & h_instr[11]) | (use_rs1 & h_instr[19]) | (use_rs2 & h_instr[24]);
    d_illegal = bad_op | bad_reg;

    // Illegal instructions still flow, but must not redirect control or touch memory.
    if (d_illegal) begin
      d_branch    = 1'b0;
      d_jump      = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
    end
  end

  // Queue bookkeeping and output stage; reset beats flush, flush beats any handshake.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      out_valid        <= 1'b0;
      out_pc           <= '0;
      out_format       <= R_TYPE;
      out_rs1          <= '0;
      out_rs2          <= '0;
      out_rd           <= '0;
      out_branch       <= 1'b0;
      out_jump         <= 1'b0;
      out_alu_imm      <= 1'b0;
      out_alu_pc       <= 1'b0;
      out_alu_op       <= ALU_ADD;
      out_mem_read     <= 1'b0;
      out_mem_write    <= 1'b0;
      out_mem_unsigned <= 1'b0;
      out_mem_size     <= '0;
      out_illegal      <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr           <= rd_ptr + PW'(1);
        out_valid        <= 1'b1;
        out_pc           <= h_pc;
        out_format       <= d_format;
        out_rs1          <= (opc == OP_LUI) ? '0 : h_instr[15 +: REG_ADDR_W];
        out_rs2          <= h_instr[20 +: REG_ADDR_W];
        out_rd           <= h_instr[7 +: REG_ADDR_W];
        out_branch       <= d_branch;
        out_jump         <= d_jump;
        out_alu_imm      <= d_alu_imm;
        out_alu_pc       <= d_alu_pc;
        out_alu_op       <= d_alu_op;
        out_mem_read     <= d_mem_read;
        out_mem_write    <= d_mem_write;
        out_mem_unsigned <= funct3[2];
        out_mem_size     <= funct3[1:0];
        out_illegal      <= d_illegal;
      end else if (out_ready) begin
        // Handshake with nothing queued behind it empties the output stage.
        out_valid <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: table of decode vectors through an RV32I
// and an RV32E instance, plus sequences for backpressure, flush and reset.
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic         in_ready, out_valid;
  logic [31:0]  out_pc;
  inst_format_t out_format;
  logic [4:0]   out_rs1, out_rs2, out_rd;
  logic         out_branch, out_jump, out_alu_imm, out_alu_pc;
  alu_op_t      out_alu_op;
  logic         out_mem_read, out_mem_write, out_mem_unsigned, out_illegal;
  logic [1:0]   out_mem_size;
  logic [2:0]   count;

  logic         e_in_ready, e_out_valid;
  logic [31:0]  e_out_pc;
  inst_format_t e_out_format;
  logic [3:0]   e_out_rs1, e_out_rs2, e_out_rd;
  logic         e_out_branch, e_out_jump, e_out_alu_imm, e_out_alu_pc;
  alu_op_t      e_out_alu_op;
  logic         e_out_mem_read, e_out_mem_write, e_out_mem_unsigned, e_out_illegal;
  logic [1:0]   e_out_mem_size;
  logic [2:0]   e_count;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_format(out_format),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_branch(out_branch), .out_jump(out_jump), .out_alu_imm(out_alu_imm), .out_alu_pc(out_alu_pc),
    .out_alu_op(out_alu_op), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_unsigned(out_mem_unsigned), .out_mem_size(out_mem_size),
    .out_illegal(out_illegal), .count(count)
  );

  decode_queue #(.DEPTH(4), .REG_ADDR_W(4)) dut_e (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc), .out_format(e_out_format),
    .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd),
    .out_branch(e_out_branch), .out_jump(e_out_jump), .out_alu_imm(e_out_alu_imm),
    .out_alu_pc(e_out_alu_pc), .out_alu_op(e_out_alu_op), .out_mem_read(e_out_mem_read),
    .out_mem_write(e_out_mem_write), .out_mem_unsigned(e_out_mem_unsigned),
    .out_mem_size(e_out_mem_size), .out_illegal(e_out_illegal), .count(e_count)
  );

  typedef struct {
    logic [31:0]  instr;
    inst_format_t fmt;
    logic [4:0]   rs1, rs2, rd;
    alu_op_t      alu_op;
    logic         br, jmp, imm, apc, mrd, mwr, mun;
    logic [1:0]   msz;
    logic         ill, e_ill, e_mwr;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ADD x(i+1), x1, x2 -- rd tags each instruction for order checks.
  function automatic logic [31:0] mk(input int i);
    return 32'h0020_8033 | (32'(i + 1) << 7);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_out;
    logic hs, seen;

    //             instr         fmt     rs1    rs2    rd     alu_op             br    jmp   imm   apc   mrd   mwr   mun   msz    ill   e_ill e_mwr
    vec[0]  = '{32'h002081B3, R_TYPE, 5'd1,  5'd2,  5'd3,  ALU_ADD,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{32'h407302B3, R_TYPE, 5'd6,  5'd7,  5'd5,  ALU_SUB,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{32'h40335293, I_TYPE, 5'd6,  5'd3,  5'd5,  ALU_SRA,           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{32'h00335293, I_TYPE, 5'd6,  5'd3,  5'd5,  ALU_SRL,           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{32'h000122B7, U_TYPE, 5'd0,  5'd0,  5'd5,  ALU_ADD,           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{32'h00412083, I_TYPE, 5'd2,  5'd4,  5'd1,  ALU_ADD,           1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{32'h00014083, I_TYPE, 5'd2,  5'd0,  5'd1,  ALU_ADD,           1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{32'h00322423, S_TYPE, 5'd4,  5'd3,  5'd8,  ALU_ADD,           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1};
    vec[8]  = '{32'h00208463, B_TYPE, 5'd1,  5'd2,  5'd8,  ALU_ADD,           1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{32'h010000EF, J_TYPE, 5'd0,  5'd16, 5'd1,  ALU_ADD,           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[10] = '{32'h00008067, I_TYPE, 5'd1,  5'd0,  5'd0,  ALU_ADD,           1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[11] = '{32'h00001517, U_TYPE, 5'd0,  5'd0,  5'd10, ALU_ADD,           1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
    vec[12] = '{32'h0000007F, I_TYPE, 5'd0,  5'd0,  5'd0,  ALU_ADD,           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    vec[13] = '{32'h402091B3, R_TYPE, 5'd1,  5'd2,  5'd3,  alu_op_t'(4'h9),   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
    vec[14] = '{32'h002088B3, R_TYPE, 5'd1,  5'd2,  5'd17, ALU_ADD,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    vec[15] = '{32'h0110A023, S_TYPE, 5'd1,  5'd17, 5'd0,  ALU_ADD,           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0};
    vec[16] = '{32'h022081B3, R_TYPE, 5'd1,  5'd2,  5'd3,  ALU_ADD,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step(); step();
    rst = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_format", out_format, R_TYPE);
    check("rst_out_alu_op", out_alu_op, ALU_ADD);

    // Decode table: one instruction at a time through an empty queue.
    for (int i = 0; i < NV; i++) begin
      in_instr = vec[i].instr; in_pc = 32'h1000 + 32'(i) * 4;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_latency_valid", i), out_valid, 0);
      check($sformatf("v%0d_latency_count", i), count, 1);
      step();
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
      check($sformatf("v%0d_format", i), out_format, vec[i].fmt);
      check($sformatf("v%0d_rs1", i), out_rs1, vec[i].rs1);
      check($sformatf("v%0d_rs2", i), out_rs2, vec[i].rs2);
      check($sformatf("v%0d_rd", i), out_rd, vec[i].rd);
      check($sformatf("v%0d_alu_op", i), out_alu_op, vec[i].alu_op);
      check($sformatf("v%0d_ctrl", i),
            {out_branch, out_jump, out_alu_imm, out_alu_pc, out_mem_read, out_mem_write, out_mem_unsigned, out_mem_size},
            {vec[i].br, vec[i].jmp, vec[i].imm, vec[i].apc, vec[i].mrd, vec[i].mwr, vec[i].mun, vec[i].msz});
      check($sformatf("v%0d_illegal", i), out_illegal, vec[i].ill);
      check($sformatf("v%0d_e_illegal", i), e_out_illegal, vec[i].e_ill);
      check($sformatf("v%0d_e_mem_write", i), e_out_mem_write, vec[i].e_mwr);
      step();
      check($sformatf("v%0d_drop_valid", i), out_valid, 0);
    end

    // Backpressure: five accepted (one staged, four queued), sixth held.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_instr = mk(i); in_pc = 32'h100 + 32'(i) * 4; in_valid = 1'b1;
      step();
    end
    check("bp_count_full", count, 4);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    in_instr = mk(5); in_pc = 32'h114;
    step(); step(); step();
    check("bp_hold_count", count, 4);
    check("bp_hold_pc", out_pc, 32'h100);
    check("bp_hold_rd", out_rd, 1);

    out_ready = 1'b1;
    n_out = 0;
    for (int cyc = 0; cyc < 40 && n_out < 6; cyc++) begin
      if (out_valid) begin
        check($sformatf("bp_order_pc%0d", n_out), out_pc, 32'h100 + 32'(n_out) * 4);
        check($sformatf("bp_order_rd%0d", n_out), out_rd, 32'(n_out + 1));
        n_out++;
      end
      hs = in_valid && in_ready;
      step();
      if (hs) in_valid = 1'b0;
    end
    check("bp_drained", n_out, 6);
    in_valid = 1'b0;
    step();
    check("bp_empty_valid", out_valid, 0);

    // Flush with three queued, a staged bundle and a concurrent push.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_instr = mk(i); in_pc = 32'h2000 + 32'(i) * 4; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("fl_pre_count", count, 3);
    check("fl_pre_valid", out_valid, 1);
    in_instr = mk(9); in_pc = 32'h2FF0; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", count, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("fl_no_ghost", seen, 0);
    in_instr = mk(2); in_pc = 32'h3000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("fl_recover_valid", out_valid, 1);
    check("fl_recover_pc", out_pc, 32'h3000);
    check("fl_recover_rd", out_rd, 3);
    step();

    // Reset mid-stream, together with flush and a push, drops everything.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_instr = vec[8].instr; in_pc = 32'h4000 + 32'(i) * 4; in_valid = 1'b1;
      step();
    end
    check("rs_pre_valid", out_valid, 1);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("rs_out_valid", out_valid, 0);
    check("rs_count", count, 0);
    check("rs_in_ready", in_ready, 1);
    check("rs_out_pc", out_pc, 0);
    check("rs_fields", {out_rs1, out_rs2, out_rd}, 0);
    check("rs_format", out_format, R_TYPE);
    check("rs_ctrl",
          {out_branch, out_jump, out_alu_imm, out_alu_pc, out_mem_read, out_mem_write, out_mem_unsigned, out_mem_size, out_illegal},
          0);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("rs_no_ghost", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
